// File: rtl/mem_stage.sv
// mem_stage: E/M pipeline register plus word/half/byte data memory with load extension; define MEM_STAGE_TRACE_EN to print committed stores.
module mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_EResult,
  input  logic [31:0] E_RData2,
  input  logic [4:0]  E_WriteA,
  input  logic [31:0] W_GRFWData,
  input  logic        Trans_DMIn_Sel,
  output logic [31:0] M_Instr,
  output logic [31:0] M_PC,
  output logic [31:0] M_EResult,
  output logic [4:0]  M_WriteA,
  output logic [31:0] M_RData2,
  output logic [31:0] MemRData
);
  logic [31:0]      dm [DM_WORDS];
  logic [5:0]       op;
  logic [DM_AW-1:0] idx;
  logic [31:0]      rd, sd, wdat, wd;
  logic [15:0]      hv;
  logic [7:0]       bv;
  logic [3:0]       be;
  logic             st;

  // E/M pipeline register; clears asynchronously so a bubble (sll $0) sits in M during reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M_Instr   <= '0;
      M_PC      <= '0;
      M_EResult <= '0;
      M_WriteA  <= '0;
      M_RData2  <= '0;
    end else begin
      M_Instr   <= E_Instr;
      M_PC      <= E_PC;
      M_EResult <= E_EResult;
      M_WriteA  <= E_WriteA;
      M_RData2  <= E_RData2;
    end
  end

  // decode, byte-enable merge of store data into the current word, and load extension
  always_comb begin
    op    = M_Instr[31:26];
    idx   = M_EResult[DM_AW+1:2];
    rd    = dm[idx];
    sd    = Trans_DMIn_Sel ? W_GRFWData : M_RData2;
    st    = op == 6'h2b || op == 6'h29 || op == 6'h28;
    be    = op == 6'h2b ? 4'hf :
            op == 6'h29 ? (M_EResult[1] ? 4'hc : 4'h3) :
            op == 6'h28 ? 4'b0001 << M_EResult[1:0] : 4'h0;
    wdat  = op == 6'h2b ? sd : op == 6'h29 ? {2{sd[15:0]}} : {4{sd[7:0]}};
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = be[i] ? wdat[8*i +: 8] : rd[8*i +: 8];
    hv    = M_EResult[1] ? rd[31:16] : rd[15:0];
    bv    = 8'(rd >> {M_EResult[1:0], 3'b000});
    MemRData = op == 6'h23 ? rd :
               op == 6'h21 ? {{16{hv[15]}}, hv} :
               op == 6'h25 ? {16'h0, hv} :
               op == 6'h20 ? {{24{bv[7]}}, bv} :
               op == 6'h24 ? {24'h0, bv} : 32'h0;
  end

  // data memory: cleared on every edge under reset, otherwise a store commits at the end of its M cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else if (st) begin
      dm[idx] <= wd;
    end
  end

`ifdef MEM_STAGE_TRACE_EN
  // store trace at the committing edge
  always_ff @(posedge clk) begin
    if (reset && st) $display("@%h: *%h <= %h", M_PC, {M_EResult[31:2], 2'b00}, wd);
  end
`else
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage loads, stores, forwarding, reset and address wrap.
module tb_mem_stage;
  logic        clk, reset;
  logic [31:0] E_Instr, E_PC, E_EResult, E_RData2, W_GRFWData;
  logic [4:0]  E_WriteA;
  logic        Trans_DMIn_Sel;
  logic [31:0] M_Instr, M_PC, M_EResult, M_RData2, MemRData;
  logic [4:0]  M_WriteA;
  logic [31:0] q [$];
  logic [31:0] pc;
  int n_chk, n_fail;

  localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
  localparam logic [5:0] SW = 6'h2b, SH = 6'h29, SB = 6'h28;

  mem_stage dut (
    .clk(clk), .reset(reset), .E_Instr(E_Instr), .E_PC(E_PC), .E_EResult(E_EResult),
    .E_RData2(E_RData2), .E_WriteA(E_WriteA), .W_GRFWData(W_GRFWData),
    .Trans_DMIn_Sel(Trans_DMIn_Sel), .M_Instr(M_Instr), .M_PC(M_PC), .M_EResult(M_EResult),
    .M_WriteA(M_WriteA), .M_RData2(M_RData2), .MemRData(MemRData)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_load(input logic [5:0] o);
    return o == LW || o == LH || o == LHU || o == LB || o == LBU;
  endfunction

  // drive one instruction from E, let it enter M, set M-cycle forwarding inputs, score loads
  task automatic step(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] rd2,
                      input logic sel, input logic [31:0] wdat, input logic [31:0] exp);
    E_Instr = instr; E_EResult = addr; E_RData2 = rd2; E_PC = pc; E_WriteA = 5'd8;
    if (is_load(instr[31:26])) q.push_back(exp);
    @(posedge clk); #1;
    Trans_DMIn_Sel = sel; W_GRFWData = wdat;
    #1;
    check("m_pc", M_PC, pc);
    check("m_eresult", M_EResult, addr);
    if (is_load(M_Instr[31:26])) begin
      if (q.size() == 0) check("sb_empty", 32'h1, 32'h0);
      else check("memrdata", MemRData, q.pop_front());
    end
    pc += 4;
  endtask

  task automatic mem(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    step({o, 26'h0}, a, d, 1'b0, 32'h0, exp);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; pc = 32'h3000;
    reset = 0; E_Instr = 0; E_PC = 0; E_EResult = 0; E_RData2 = 0; E_WriteA = 0;
    W_GRFWData = 0; Trans_DMIn_Sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", M_Instr, 0);
    check("rst_pc", M_PC, 0);
    check("rst_eres", M_EResult, 0);
    check("rst_wa", {27'h0, M_WriteA}, 0);
    check("rst_rd2", M_RData2, 0);
    reset = 1;
    mem(LW, 32'h0, 0, 32'h0);
    mem(LW, 32'h4, 0, 32'h0);
    mem(LW, 32'hffc, 0, 32'h0);
    mem(SW, 32'h10, 32'h12345678, 0);
    check("sw_wa", {27'h0, M_WriteA}, 8);
    mem(LW, 32'h10, 0, 32'h12345678);
    mem(SB, 32'h11, 32'h000000ab, 0);
    mem(SH, 32'h12, 32'h0000beef, 0);
    mem(LW, 32'h10, 0, 32'hbeefab78);
    mem(LB, 32'h11, 0, 32'hffffffab);
    mem(LBU, 32'h11, 0, 32'h000000ab);
    mem(LH, 32'h12, 0, 32'hffffbeef);
    mem(LHU, 32'h12, 0, 32'h0000beef);
    mem(LB, 32'h10, 0, 32'h00000078);
    mem(LH, 32'h10, 0, 32'hffffab78);
    step({SW, 26'h0}, 32'h40, 32'h1111, 1'b1, 32'h2222, 0);
    mem(LW, 32'h40, 0, 32'h2222);
    step({SW, 26'h0}, 32'h40, 32'h1111, 1'b0, 32'h2222, 0);
    mem(LW, 32'h40, 0, 32'h1111);
    mem(SW, 32'h20, 32'h5555, 0);
    reset = 0;
    #1;
    check("mid_instr", M_Instr, 0);
    check("mid_pc", M_PC, 0);
    check("mid_eres", M_EResult, 0);
    check("mid_rd2", M_RData2, 0);
    check("mid_wa", {27'h0, M_WriteA}, 0);
    @(posedge clk); #1;
    reset = 1;
    mem(LW, 32'h20, 0, 32'h0);
    mem(LW, 32'h10, 0, 32'h0);
    mem(SW, 32'h1004, 32'hcafe, 0);
    mem(LW, 32'h4, 0, 32'hcafe);
    step(32'h00851021, 32'h4, 32'h77777777, 1'b0, 32'h0, 0);
    check("addu_rdata", MemRData, 0);
    mem(LW, 32'h4, 0, 32'hcafe);
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
